focus_sharpness_stat: RTL and testbench

//  Inline Avalon-ST video pass-through stage, placed directly upstream of the auto-focus/VCM controller.

---
 rtl/focus_sharpness_stat_if.sv | 12 +
 rtl/focus_sharpness_stat.sv | 201 ++++++++++++++++++++
 tb/tb_focus_sharpness_stat.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/focus_sharpness_stat_if.sv
// focus_sharpness_stat_if: one Avalon-ST video beat bundle carrying 30-bit RGB data,
// sop/eop framing and ready backpressure; master drives the beat, slave drives ready.
interface focus_sharpness_stat_if;
    logic [29:0] data;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/focus_sharpness_stat.sv
// focus_sharpness_stat: Avalon-ST video pass-through that sums thresholded horizontal luma
// gradients inside a programmable window and publishes a per-frame sharpness over Avalon-MM.
module focus_sharpness_stat #(
    parameter int VIDEO_W = 800,
    parameter int VIDEO_H = 480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_chipselect,
    input  logic                    s_read,
    input  logic                    s_write,
    input  logic [2:0]              s_address,
    input  logic [31:0]             s_writedata,
    output logic [31:0]             s_readdata,
    focus_sharpness_stat_if.slave   sink,
    focus_sharpness_stat_if.master  source,
    output logic                    frame_done
);
    localparam logic [11:0] X_LAST = 12'(VIDEO_W - 1);
    localparam logic [11:0] Y_LAST = 12'(VIDEO_H - 1);

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic        en_r;
    logic [9:0]  th_r, th_act_r;
    logic [11:0] win_x_r, win_y_r, win_w_r, win_h_r;
    logic [11:0] win_x_act_r, win_y_act_r, win_w_act_r, win_h_act_r;
    logic        in_video_r;
    logic [11:0] x_r, y_r;
    logic [9:0]  yprev_r;
    logic        s1_valid_r, s1_eop_r, s1_hot_r;
    logic [9:0]  s1_grad_r;
    logic [31:0] acc_r, result_r;
    logic [19:0] edges_r, edges_snap_r;
    logic [15:0] frame_cnt_r;
    logic        done_r;

    logic        accept_s, sop_beat_s, pix_s, wr_s;
    logic [11:0] ysum_s;
    logic [9:0]  y_s, grad_s;
    logic        x_in_s, y_in_s, hot_s, qual_s, fin_s;
    logic [32:0] acc_sum_s;
    logic [31:0] acc_next_s, rd_mux_s;
    logic [19:0] edges_next_s;
    logic        unused_bits_s;

    assign source.data  = sink.data;
    assign source.valid = sink.valid;
    assign source.sop   = sink.sop;
    assign source.eop   = sink.eop;
    assign sink.ready   = source.ready;

    assign accept_s   = sink.valid & source.ready;
    assign sop_beat_s = accept_s & sink.sop;
    assign pix_s      = accept_s & ~sink.sop & in_video_r;
    assign wr_s       = s_chipselect & s_write;
    // EDGES snapshot has no register slot; upper write bits are don't-care.
    assign unused_bits_s = ^{s_writedata[31:12], edges_snap_r};

    // Luma, gradient, window test and stage-2 accumulate/saturate arithmetic.
    always_comb begin
        ysum_s    = {2'b00, sink.data[29:20]} + {1'b0, sink.data[19:10], 1'b0} + {2'b00, sink.data[9:0]};
        y_s       = ysum_s[11:2];
        grad_s    = (x_r == 12'd0) ? 10'd0 : abs_diff(y_s, yprev_r);
        x_in_s    = ({1'b0, x_r} >= {1'b0, win_x_act_r}) &&
                    ({1'b0, x_r} <  ({1'b0, win_x_act_r} + {1'b0, win_w_act_r}));
        y_in_s    = ({1'b0, y_r} >= {1'b0, win_y_act_r}) &&
                    ({1'b0, y_r} <  ({1'b0, win_y_act_r} + {1'b0, win_h_act_r}));
        hot_s     = x_in_s & y_in_s & (grad_s > th_act_r);
        qual_s    = s1_valid_r & s1_hot_r & en_r;
        fin_s     = s1_valid_r & s1_eop_r & en_r;
        acc_sum_s = {1'b0, acc_r} + {23'd0, s1_grad_r};
        if (qual_s) begin
            acc_next_s   = acc_sum_s[32] ? 32'hFFFF_FFFF : acc_sum_s[31:0];
            edges_next_s = (edges_r == 20'hF_FFFF) ? edges_r : (edges_r + 20'd1);
        end else begin
            acc_next_s   = acc_r;
            edges_next_s = edges_r;
        end
    end

    // Register read multiplexer.
    always_comb begin
        case (s_address)
            3'd0:    rd_mux_s = {31'd0, en_r};
            3'd1:    rd_mux_s = {22'd0, th_r};
            3'd2:    rd_mux_s = {20'd0, win_x_r};
            3'd3:    rd_mux_s = {20'd0, win_y_r};
            3'd4:    rd_mux_s = {20'd0, win_w_r};
            3'd5:    rd_mux_s = {20'd0, win_h_r};
            3'd6:    rd_mux_s = result_r;
            3'd7:    rd_mux_s = {frame_cnt_r, 15'd0, done_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Software-visible configuration registers and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r       <= 1'b0;
            th_r       <= 10'd16;
            win_x_r    <= 12'd300;
            win_y_r    <= 12'd180;
            win_w_r    <= 12'd200;
            win_h_r    <= 12'd120;
            s_readdata <= 32'd0;
        end else begin
            if (wr_s) begin
                case (s_address)
                    3'd0:    en_r    <= s_writedata[0];
                    3'd1:    th_r    <= s_writedata[9:0];
                    3'd2:    win_x_r <= s_writedata[11:0];
                    3'd3:    win_y_r <= s_writedata[11:0];
                    3'd4:    win_w_r <= s_writedata[11:0];
                    3'd5:    win_h_r <= s_writedata[11:0];
                    default: ;
                endcase
            end
            if (s_chipselect && s_read) begin
                s_readdata <= rd_mux_s;
            end
        end
    end

    // Packet tracking, pixel counters, shadow capture and pipeline stage 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_video_r  <= 1'b0;
            x_r         <= 12'd0;
            y_r         <= 12'd0;
            yprev_r     <= 10'd0;
            th_act_r    <= 10'd16;
            win_x_act_r <= 12'd300;
            win_y_act_r <= 12'd180;
            win_w_act_r <= 12'd200;
            win_h_act_r <= 12'd120;
            s1_valid_r  <= 1'b0;
            s1_eop_r    <= 1'b0;
            s1_hot_r    <= 1'b0;
            s1_grad_r   <= 10'd0;
        end else begin
            s1_valid_r <= pix_s;
            s1_eop_r   <= pix_s & sink.eop;
            if (sop_beat_s) begin
                in_video_r <= (sink.data[3:0] == 4'd0);
                x_r        <= 12'd0;
                y_r        <= 12'd0;
                if (sink.data[3:0] == 4'd0) begin
                    th_act_r    <= th_r;
                    win_x_act_r <= win_x_r;
                    win_y_act_r <= win_y_r;
                    win_w_act_r <= win_w_r;
                    win_h_act_r <= win_h_r;
                end
            end else if (pix_s) begin
                yprev_r   <= y_s;
                s1_grad_r <= grad_s;
                s1_hot_r  <= hot_s;
                if (x_r == X_LAST) begin
                    x_r <= 12'd0;
                    y_r <= (y_r == Y_LAST) ? y_r : (y_r + 12'd1);
                end else begin
                    x_r <= x_r + 12'd1;
                end
                if (sink.eop) begin
                    in_video_r <= 1'b0;
                end
            end
        end
    end

    // Stage 2: accumulate qualifying gradients and publish the frame result at eop.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r        <= 32'd0;
            edges_r      <= 20'd0;
            result_r     <= 32'd0;
            edges_snap_r <= 20'd0;
            frame_cnt_r  <= 16'd0;
            done_r       <= 1'b0;
            frame_done   <= 1'b0;
        end else if (fin_s) begin
            result_r     <= acc_next_s;
            edges_snap_r <= edges_next_s;
            acc_r        <= 32'd0;
            edges_r      <= 20'd0;
            frame_cnt_r  <= frame_cnt_r + 16'd1;
            done_r       <= 1'b1;
            frame_done   <= 1'b1;
        end else begin
            acc_r      <= acc_next_s;
            edges_r    <= edges_next_s;
            frame_done <= 1'b0;
            if (wr_s && (s_address == 3'd7) && s_writedata[0]) begin
                done_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_focus_sharpness_stat.sv
// Bench for focus_sharpness_stat on a reduced 16x8 raster: directed frames, expected
// register reads and frame_done timing queued by the stimulus and checked by a monitor.
module tb_focus_sharpness_stat;
    localparam int W = 16;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, rd, wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        frame_done;

    focus_sharpness_stat_if snk ();
    focus_sharpness_stat_if src ();

    focus_sharpness_stat #(.VIDEO_W(W), .VIDEO_H(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_chipselect (cs),
        .s_read       (rd),
        .s_write      (wr),
        .s_address    (addr),
        .s_writedata  (wdata),
        .s_readdata   (rdata),
        .sink         (snk),
        .source       (src),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          pt_bad = 0;
    bit          rnd_ready = 1'b0;
    logic        rd_pend = 1'b0;
    logic [31:0] exp_rd_q[$];
    string       exp_rd_name_q[$];
    int          exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, act, exp, exp);
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= cs & rd;
    end

    // Monitor: read data, frame_done timing and stream pass-through.
    always @(negedge clk) begin
        if (rd_pend) begin
            check(exp_rd_name_q.pop_front(), rdata, exp_rd_q.pop_front());
        end
        if (frame_done === 1'b1) begin
            if (exp_done_q.size() == 0) check("spurious frame_done", {31'd0, frame_done}, 32'd0);
            else check("frame_done latency (cycle)", 32'(cyc), 32'(exp_done_q.pop_front()));
        end
        if (src.data !== snk.data || src.valid !== snk.valid || src.sop !== snk.sop ||
            src.eop !== snk.eop || snk.ready !== src.ready) pt_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic mm_read(input logic [2:0] a, input logic [31:0] e, input string name);
        exp_rd_q.push_back(e);
        exp_rd_name_q.push_back(name);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic send_beat(input logic [29:0] d, input logic sop, input logic eop, input bit counted_eop);
        bit taken;
        snk.data = d; snk.valid = 1'b1; snk.sop = sop; snk.eop = eop;
        do begin
            src.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            taken = src.ready;
            cs = 1'b0; wr = 1'b0;
        end while (!taken);
        if (counted_eop) exp_done_q.push_back(cyc + 1);
    endtask

    // kind 0: constant 512 grey; kind 1: Y alternating 0/400 per pixel.
    task automatic send_frame(input int kind, input bit ctl, input bit mid_wr, input bit counted);
        logic [9:0] v;
        if (ctl) begin
            send_beat(30'h0000000F, 1'b1, 1'b0, 1'b0);
            send_beat({10'd1, 10'd2, 10'd3}, 1'b0, 1'b0, 1'b0);
            send_beat({10'd700, 10'd5, 10'd900}, 1'b0, 1'b0, 1'b0);
            send_beat({10'd9, 10'd8, 10'd7}, 1'b0, 1'b1, 1'b0);
        end
        send_beat(30'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W * H; i++) begin
            if (kind == 0) v = 10'd512;
            else v = (((i % W) % 2) == 1) ? 10'd400 : 10'd0;
            if (mid_wr && i == 40) begin
                cs = 1'b1; wr = 1'b1; addr = 3'd4; wdata = 32'd10;
            end
            send_beat({v, v, v}, 1'b0, (i == W * H - 1), counted && (i == W * H - 1));
        end
        snk.valid = 1'b0; snk.eop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'd0;
        snk.data = 30'd0; snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0; src.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset s_readdata", rdata, 32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        idle(1);
        mm_read(3'd0, 32'd0,   "reset CTRL");
        mm_read(3'd1, 32'd16,  "reset TH");
        mm_read(3'd2, 32'd300, "reset WIN_X");
        mm_read(3'd3, 32'd180, "reset WIN_Y");
        mm_read(3'd4, 32'd200, "reset WIN_W");
        mm_read(3'd5, 32'd120, "reset WIN_H");
        mm_read(3'd6, 32'd0,   "reset RESULT");
        mm_read(3'd7, 32'd0,   "reset STATUS");

        // Flat grey frame, full window.
        mm_write(3'd0, 32'd1); mm_write(3'd2, 32'd0); mm_write(3'd3, 32'd0);
        mm_write(3'd4, 32'd16); mm_write(3'd5, 32'd8);
        send_frame(0, 1'b0, 1'b0, 1'b1); idle(4);
        mm_read(3'd6, 32'd0, "flat RESULT");
        mm_read(3'd7, {16'd1, 15'd0, 1'b1}, "flat STATUS");
        mm_write(3'd7, 32'd1);
        mm_read(3'd7, {16'd1, 16'd0}, "STATUS after DONE clear");

        // Stripes in a 6x4 window at (4,2): 6*4*400.
        mm_write(3'd2, 32'd4); mm_write(3'd3, 32'd2); mm_write(3'd4, 32'd6); mm_write(3'd5, 32'd4);
        send_frame(1, 1'b0, 1'b0, 1'b1); idle(4);
        mm_read(3'd6, 32'd9600, "stripes RESULT");

        mm_write(3'd1, 32'd400);
        send_frame(1, 1'b0, 1'b0, 1'b1); idle(4);
        mm_read(3'd6, 32'd0, "TH=400 strict RESULT");
        mm_write(3'd1, 32'd399);
        send_frame(1, 1'b0, 1'b0, 1'b1); idle(4);
        mm_read(3'd6, 32'd9600, "TH=399 RESULT");
        mm_write(3'd1, 32'd16);

        send_frame(1, 1'b1, 1'b0, 1'b1); idle(4);
        mm_read(3'd6, 32'd9600, "control packet first RESULT");
        check("pass-through after control packet", 32'(pt_bad), 32'd0);

        rnd_ready = 1'b1;
        send_frame(1, 1'b0, 1'b0, 1'b1);
        rnd_ready = 1'b0; src.ready = 1'b1;
        idle(4);
        mm_read(3'd6, 32'd9600, "random backpressure RESULT");
        check("pass-through under backpressure", 32'(pt_bad), 32'd0);

        // WIN_W written mid-frame; DONE clear lands on the frame-end cycle.
        send_frame(1, 1'b0, 1'b1, 1'b1);
        mm_write(3'd7, 32'd1);
        idle(4);
        mm_read(3'd6, 32'd9600, "mid-frame WIN_W write RESULT");
        mm_read(3'd7, {16'd7, 15'd0, 1'b1}, "DONE set beats clear");
        send_frame(1, 1'b0, 1'b0, 1'b1); idle(4);
        mm_read(3'd6, 32'd16000, "next frame WIN_W=10 RESULT");

        mm_write(3'd0, 32'd0);
        send_frame(1, 1'b0, 1'b0, 1'b0); idle(4);
        mm_read(3'd6, 32'd16000, "en=0 RESULT held");
        mm_read(3'd7, {16'd8, 15'd0, 1'b1}, "en=0 frame_cnt held");
        mm_write(3'd0, 32'd1);
        mm_write(3'd6, 32'h0000_1234);
        mm_read(3'd6, 32'd16000, "RESULT read-only");

        send_beat(30'd0, 1'b0, 1'b1, 1'b0);
        snk.valid = 1'b0; snk.eop = 1'b0;
        idle(4);
        mm_read(3'd7, {16'd8, 15'd0, 1'b1}, "stray eop ignored");
        idle(2);
        check("all expected reads seen", 32'(exp_rd_q.size()), 32'd0);
        check("all expected frame_done seen", 32'(exp_done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
